mc_fetch_unit: RTL and testbench

- Parametrised program-counter and instruction-register front end for the multicycle core.
- Replaces the fixed pcreg/temp_pcreg/intreg/conditional-PC-write cluster with one block.
- Adds a wait-state memory handshake with timeout, auto-increment, and redirect while a fetch is in flight.
- Sits between the control FSM, the instruction memory, and the ALU/register-file PC sources.

---
 rtl/mc_pkg.sv | 18 +
 rtl/mc_redirect_ctl.sv | 59 +++++
 rtl/mc_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_mc_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle core fetch front end.
package mc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEF = 2;

  localparam logic FLAG_Z  = 1'b0;
  localparam logic FLAG_NZ = 1'b1;

  localparam logic PCSRC_ALU = 1'b0;
  localparam logic PCSRC_REG = 1'b1;

endpackage

// File: rtl/mc_redirect_ctl.sv
// Redirect decode (condition and target select) plus the pending-target register
// that holds a redirect arriving while a fetch is in flight.
module mc_redirect_ctl
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              clear,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              flag_sel,
  input  logic              zero_f,
  input  logic              pc_src,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] reg_val,
  output logic              redir,
  output logic [ADDR_W-1:0] target,
  output logic              take_valid,
  output logic [ADDR_W-1:0] take_target
);

  logic              flag;
  logic [DATA_W-1:0] src;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_target_q;

  assign flag   = (flag_sel == FLAG_Z) ? zero_f : ~zero_f;
  assign redir  = pc_write | (pc_write_cond & flag);
  assign src    = (pc_src == PCSRC_REG) ? reg_val : alu_out;
  assign target = src[ADDR_W-1:0];

  generate
    if (DATA_W > ADDR_W) begin : g_drop_hi
      logic unused_src_hi;
      assign unused_src_hi = ^src[DATA_W-1:ADDR_W];
    end
  endgenerate

  // A redirect in the same cycle as completion is treated as already pending.
  assign take_valid  = pend_valid_q | (busy & redir);
  assign take_target = (busy & redir) ? target : pend_target_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (clear) begin
      pend_valid_q  <= 1'b0;
    end else if (busy && redir) begin
      pend_valid_q  <= 1'b1;
      pend_target_q <= target;
    end
  end

endmodule

// File: rtl/mc_fetch_unit.sv
// PC / IR front end: issues instruction fetches with a wait-state handshake and
// timeout, auto-increments the PC, and defers redirects that arrive mid-fetch.
module mc_fetch_unit
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned PC_STEP   = PC_STEP_DEF,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  output logic              fetch_done,
  output logic              fetch_squash,
  output logic              bus_err,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              flag_sel,
  input  logic              zero_f,
  input  logic              pc_src,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] reg_val
);

  localparam int unsigned       CntW   = 8;
  localparam logic [ADDR_W-1:0] RstPc  = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(PC_STEP);
  localparam logic [CntW-1:0]   CntMax = CntW'(MAX_WAIT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              pend_req_q, pend_req_d;
  logic              bus_err_q, bus_err_d;
  logic              squash_q, squash_d;

  logic              busy;
  logic              clear;
  logic              redir;
  logic [ADDR_W-1:0] target;
  logic              take_valid;
  logic [ADDR_W-1:0] take_target;

  assign busy = (state_q == StBusy);

  mc_redirect_ctl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_redirect_ctl (
    .clk           (clk),
    .rst           (rst),
    .busy          (busy),
    .clear         (clear),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .flag_sel      (flag_sel),
    .zero_f        (zero_f),
    .pc_src        (pc_src),
    .alu_out       (alu_out),
    .reg_val       (reg_val),
    .redir         (redir),
    .target        (target),
    .take_valid    (take_valid),
    .take_target   (take_target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    wait_d     = wait_q;
    pend_req_d = 1'b0;
    bus_err_d  = bus_err_q;
    squash_d   = squash_q;
    clear      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (redir) begin
          // Let the PC settle first; the fetch goes out next cycle at the new PC.
          pc_d       = target;
          pend_req_d = fetch_req | pend_req_q;
        end else if (fetch_req || pend_req_q) begin
          state_d = StBusy;
          addr_d  = pc_q;
          wait_d  = '0;
        end
      end
      StBusy: begin
        if (imem_ack) begin
          clear    = 1'b1;
          squash_d = take_valid;
          state_d  = StDone;
          if (take_valid) begin
            pc_d = take_target;
          end else begin
            ir_d = imem_rdata;
            pc_d = pc_q + PcStep;
          end
        end else if (wait_q == CntMax) begin
          clear     = 1'b1;
          squash_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
          if (take_valid) begin
            pc_d = take_target;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        state_d  = StIdle;
        squash_d = 1'b0;
        if (redir) begin
          pc_d = target;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RstPc;
      addr_q     <= '0;
      ir_q       <= '0;
      wait_q     <= '0;
      pend_req_q <= 1'b0;
      bus_err_q  <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      wait_q     <= wait_d;
      pend_req_q <= pend_req_d;
      bus_err_q  <= bus_err_d;
      squash_q   <= squash_d;
    end
  end

  assign imem_req     = busy;
  assign imem_addr    = addr_q;
  assign fetch_done   = (state_q == StDone);
  assign fetch_squash = (state_q == StDone) & squash_q;
  assign bus_err      = bus_err_q;
  assign ir           = ir_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed plus randomized bench for mc_fetch_unit against a transaction-level
// model of PC, IR and bus-error state.
module tb_mc_fetch_unit;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_req = 1'b0;
  logic              fetch_done;
  logic              fetch_squash;
  logic              bus_err;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic              pc_write = 1'b0;
  logic              pc_write_cond = 1'b0;
  logic              flag_sel = 1'b0;
  logic              zero_f = 1'b0;
  logic              pc_src = 1'b0;
  logic [DATA_W-1:0] alu_out = '0;
  logic [DATA_W-1:0] reg_val = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_ir;
  logic              m_err;

  mc_fetch_unit #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PC_STEP   (2),
    .RESET_VEC (0),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_done    (fetch_done),
    .fetch_squash  (fetch_squash),
    .bus_err       (bus_err),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .pc            (pc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .flag_sel      (flag_sel),
    .zero_f        (zero_f),
    .pc_src        (pc_src),
    .alu_out       (alu_out),
    .reg_val       (reg_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_ir"}, ir, m_ir);
    check({tag, "_err"}, bus_err, m_err);
  endtask

  // One IDLE cycle of redirect inputs; a stray ack is driven to show it is ignored.
  task automatic idle_redir(input logic wc, input logic cond, input logic fsel, input logic zf,
                            input logic src, input logic [15:0] alu, input logic [15:0] rv);
    logic flag;
    pc_write = wc; pc_write_cond = cond; flag_sel = fsel; zero_f = zf;
    pc_src = src; alu_out = alu; reg_val = rv;
    imem_ack = 1'b1; imem_rdata = 16'($urandom);
    @(negedge clk);
    pc_write = 1'b0; pc_write_cond = 1'b0; imem_ack = 1'b0;
    flag = fsel ? ~zf : zf;
    if (wc || (cond && flag)) m_pc = src ? rv[14:0] : alu[14:0];
    check_state("idle");
    check("idle_req", imem_req, 0);
    check("idle_done", fetch_done, 0);
  endtask

  // Full fetch: waits >= MAX_WAIT means no ack (timeout). redir_cyc is the BUSY
  // cycle (1-based) carrying a pc_write to reg_val=rv; 0 for none.
  task automatic fetch(input int waits, input logic [15:0] data, input int redir_cyc,
                       input logic [15:0] rv, input bit issue_redir, input logic [15:0] itgt,
                       input bit done_redir, input logic [15:0] dtgt);
    logic              pend;
    logic [ADDR_W-1:0] ptgt;
    logic [ADDR_W-1:0] addr;
    bit                tmo;
    int                nb;
    pend = 1'b0;
    ptgt = '0;
    fetch_req = 1'b1;
    if (issue_redir) begin pc_write = 1'b1; pc_src = 1'b0; alu_out = itgt; end
    @(negedge clk);
    fetch_req = 1'b0; pc_write = 1'b0;
    if (issue_redir) begin
      m_pc = itgt[14:0];
      check("issue_hold_req", imem_req, 0);
      check("issue_pc", pc, m_pc);
      @(negedge clk);
    end
    addr = m_pc;
    tmo  = (waits >= int'(MAX_WAIT));
    nb   = tmo ? int'(MAX_WAIT) : waits + 1;
    for (int c = 1; c <= nb; c++) begin
      check("busy_req", imem_req, 1);
      check("busy_addr", imem_addr, addr);
      check("busy_done", fetch_done, 0);
      check("busy_pc", pc, addr);
      check("busy_err", bus_err, m_err);
      if (c == redir_cyc) begin
        pc_write = 1'b1; pc_src = 1'b1; reg_val = rv;
        pend = 1'b1; ptgt = rv[14:0];
      end
      if (!tmo && c == nb) begin imem_ack = 1'b1; imem_rdata = data; end
      @(negedge clk);
      pc_write = 1'b0; imem_ack = 1'b0;
    end
    if (tmo) begin
      m_err = 1'b1;
      if (pend) m_pc = ptgt;
    end else if (pend) begin
      m_pc = ptgt;
    end else begin
      m_ir = data;
      m_pc = m_pc + 15'd2;
    end
    check("done_pulse", fetch_done, 1);
    check("done_squash", fetch_squash, 32'(!tmo && pend));
    check("done_req", imem_req, 0);
    check_state("done");
    if (done_redir) begin
      fetch_req = 1'b1; pc_write = 1'b1; pc_src = 1'b0; alu_out = dtgt;
    end
    @(negedge clk);
    fetch_req = 1'b0; pc_write = 1'b0;
    if (done_redir) m_pc = dtgt[14:0];
    check("post_done", fetch_done, 0);
    check("post_req", imem_req, 0);
    check_state("post");
  endtask

  initial begin
    m_pc = '0; m_ir = '0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_req", imem_req, 0);
    check("rst_done", fetch_done, 0);
    check("rst_squash", fetch_squash, 0);
    check("rst_err", bus_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch, then three wait states.
    fetch(0, 16'hA123, 0, '0, 1'b0, '0, 1'b0, '0);
    check("zw_pc", pc, 15'd2);
    fetch(3, 16'h5F00, 0, '0, 1'b0, '0, 1'b0, '0);
    check("ws_pc", pc, 15'd4);

    // Conditional redirect taken (flag = zero) and not taken (flag = ~zero).
    idle_redir(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    check("cond_taken_pc", pc, 15'h40);
    idle_redir(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
    check("cond_nt_pc", pc, 15'h40);

    // Redirect two cycles before ack squashes the fetch.
    fetch(2, 16'hBEEF, 1, 16'h0100, 1'b0, '0, 1'b0, '0);
    check("squash_pc", pc, 15'h100);
    check("squash_ir", ir, 16'h5F00);

    // Redirect coincident with ack, redirect with fetch_req, redirect in DONE.
    fetch(1, 16'h1111, 2, 16'h0222, 1'b0, '0, 1'b0, '0);
    fetch(0, 16'h2222, 0, '0, 1'b1, 16'h8300, 1'b1, 16'h0500);

    // PC wrap.
    idle_redir(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFE, 16'h0000);
    fetch(0, 16'h3C3C, 0, '0, 1'b0, '0, 1'b0, '0);
    check("wrap_pc", pc, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle_redir(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom));
      end else begin
        automatic int w = int'($urandom_range(0, MAX_WAIT - 1));
        fetch(w, 16'($urandom), int'($urandom_range(0, w + 1)), 16'($urandom),
              1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      end
    end

    // Timeout without redirect, sticky error, then timeout with a pending redirect.
    fetch(MAX_WAIT, 16'hDEAD, 0, '0, 1'b0, '0, 1'b0, '0);
    check("tmo_err", bus_err, 1);
    fetch(0, 16'h4444, 0, '0, 1'b0, '0, 1'b0, '0);
    check("err_sticky", bus_err, 1);
    fetch(MAX_WAIT, 16'hDEAD, 2, 16'h0777, 1'b0, '0, 1'b0, '0);
    check("tmo_redir_pc", pc, 15'h777);

    // Async reset in the middle of a fetch.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    check("pre_rst_req", imem_req, 1);
    #2 rst = 1'b0;
    #1;
    m_pc = '0; m_ir = '0; m_err = 1'b0;
    check("arst_req", imem_req, 0);
    check_state("arst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("arst_nodone", fetch_done, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("arst_rel_done", fetch_done, 0);
    check("arst_rel_req", imem_req, 0);
    check_state("arst_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
